// File: rtl/skew_fifo_array.sv
// Bank of per-lane FIFOs loaded from a shared bus and drained with a diagonal
// skew (lane i starts i cycles after lane 0) to feed the edge of a systolic array.
module skew_fifo_array #(
  parameter int DATA_SIZE  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int LOG_DEPTH  = 4,
  parameter int ARRAY_SIZE = 9,
  parameter int LANE_BITS  = 4
) (
  input  logic                            clk,
  input  logic                            clear,
  input  logic                            w_en,
  input  logic [LANE_BITS-1:0]            w_lane,
  input  logic                            broadcast,
  input  logic [DATA_SIZE-1:0]            in_bus,
  input  logic                            start,
  input  logic [LOG_DEPTH:0]              drain_len,
  output logic [DATA_SIZE*ARRAY_SIZE-1:0] out_bus,
  output logic [ARRAY_SIZE-1:0]           out_valid,
  output logic                            busy,
  output logic                            done,
  output logic [ARRAY_SIZE-1:0]           empty,
  output logic [ARRAY_SIZE-1:0]           full,
  output logic                            err
);
  localparam int T_W = $clog2(FIFO_DEPTH + ARRAY_SIZE + 1);

  typedef enum logic {IDLE, DRAIN} state_e;

  state_e                        state_q, state_d;
  logic [T_W-1:0]                t_q, t_d, last_t;
  logic [LOG_DEPTH:0]            len_q, len_d;
  logic [DATA_SIZE-1:0]          mem_q [ARRAY_SIZE][FIFO_DEPTH];
  logic [LOG_DEPTH-1:0]          rptr_q [ARRAY_SIZE];
  logic [LOG_DEPTH-1:0]          rptr_d [ARRAY_SIZE];
  logic [LOG_DEPTH-1:0]          wptr_q [ARRAY_SIZE];
  logic [LOG_DEPTH-1:0]          wptr_d [ARRAY_SIZE];
  logic [LOG_DEPTH:0]            cnt_q  [ARRAY_SIZE];
  logic [LOG_DEPTH:0]            cnt_d  [ARRAY_SIZE];
  logic [ARRAY_SIZE-1:0]         lane_sel, push, pop, underflow, in_slot;
  logic [DATA_SIZE*ARRAY_SIZE-1:0] out_bus_q, out_bus_d;
  logic [ARRAY_SIZE-1:0]         out_valid_q, out_valid_d;
  logic                          done_q, done_d, err_q, err_d;
  logic                          lane_oob, wr_err;

  always_comb begin
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      empty[i] = (cnt_q[i] == '0);
      full[i]  = (cnt_q[i] == (LOG_DEPTH+1)'(FIFO_DEPTH));
    end
  end

  // Last drain cycle: the window of the highest lane closes at t = L+ARRAY_SIZE-2.
  assign last_t = (len_q == '0) ? '0 : T_W'(len_q) + T_W'(ARRAY_SIZE - 2);

  // Write decode: writes only land in IDLE; a rejected lane stays untouched.
  always_comb begin
    lane_oob = (w_lane >= LANE_BITS'(ARRAY_SIZE));
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      lane_sel[i] = broadcast || (w_lane == LANE_BITS'(i));
      push[i]     = w_en && (state_q == IDLE) && lane_sel[i] && !full[i];
    end
    wr_err = w_en && ((state_q == DRAIN) ||
                      (broadcast ? (|full) : (lane_oob || (|(lane_sel & full)))));
  end

  always_comb begin
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      in_slot[i]   = (state_q == DRAIN) && (int'(t_q) >= i) && (int'(t_q) < i + int'(len_q));
      pop[i]       = in_slot[i] && !empty[i];
      underflow[i] = in_slot[i] && empty[i];
    end
  end

  always_comb begin
    out_bus_d   = '0;
    out_valid_d = '0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      rptr_d[i] = rptr_q[i];
      wptr_d[i] = wptr_q[i];
      cnt_d[i]  = cnt_q[i];
      if (push[i]) begin
        wptr_d[i] = wptr_q[i] + 1'b1;
        cnt_d[i]  = cnt_q[i] + 1'b1;
      end
      if (pop[i]) begin
        rptr_d[i]                           = rptr_q[i] + 1'b1;
        cnt_d[i]                            = cnt_q[i] - 1'b1;
        out_bus_d[i*DATA_SIZE +: DATA_SIZE] = mem_q[i][rptr_q[i]];
        out_valid_d[i]                      = 1'b1;
      end
    end
    err_d = err_q || wr_err || (|underflow);
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    len_d   = len_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRAIN;
          t_d     = '0;
          len_d   = drain_len;
        end
      end
      DRAIN: begin
        t_d = t_q + 1'b1;
        if (t_q == last_t) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      if (!clear && push[i]) mem_q[i][wptr_q[i]] <= in_bus;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= IDLE;
      t_q         <= '0;
      len_q       <= '0;
      out_bus_q   <= '0;
      out_valid_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < ARRAY_SIZE; i++) begin
        rptr_q[i] <= '0;
        wptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      len_q       <= len_d;
      out_bus_q   <= out_bus_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rptr_q      <= rptr_d;
      wptr_q      <= wptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_bus   = out_bus_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == DRAIN);
  assign done      = done_q;
  assign err       = err_q;
endmodule
